// File: rtl/pe_switch_sequencer_if.sv
// Configuration/control and crossbar-select bundle between the array loader and one PE
// switch sequencer. Handshake: start/cfg_we are single-cycle strobes sampled on the rising clock edge.
interface pe_switch_sequencer_if #(
  parameter int CTX_AW = 4,
  parameter int HOLD_W = 4,
  parameter int ITER_W = 8
);
  logic                  cfg_we;
  logic [CTX_AW-1:0]     cfg_addr;
  logic [24+HOLD_W-1:0]  cfg_data;
  logic [CTX_AW:0]       cfg_len;
  logic [ITER_W-1:0]     cfg_iter;
  logic                  start;
  logic                  stall;
  logic                  abort;
  logic [23:0]           switch;
  logic [CTX_AW-1:0]     ctx_idx;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_len, cfg_iter, start, stall, abort,
    input  switch, ctx_idx, busy, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_len, cfg_iter, start, stall, abort,
    output switch, ctx_idx, busy, done, cfg_err
  );
endinterface

// File: rtl/pe_switch_sequencer.sv
// Context sequencer for one PE crossbar: replays stored switch words, each for hold+1 cycles,
// for a programmed number of passes, then parks the crossbar on the all-ones idle pattern.
module pe_switch_sequencer #(
  parameter int CTX_DEPTH = 16,
  parameter int CTX_AW    = 4,
  parameter int HOLD_W    = 4,
  parameter int ITER_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  pe_switch_sequencer_if.slave    bus,
  output logic [1:0]              state_o
);

  localparam int                WORD_W      = 24 + HOLD_W;
  localparam logic [23:0]       IDLE_SWITCH = 24'hFFFFFF;
  localparam logic [CTX_AW:0]   DEPTH_L     = (CTX_AW+1)'(CTX_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   mem_q [CTX_DEPTH];
  logic [23:0]         switch_q, switch_d;
  logic [CTX_AW-1:0]   idx_q, idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [ITER_W-1:0]   pass_q, pass_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [CTX_AW:0]     len_q, len_d;
  logic                err_q, err_d;

  logic                mem_we;
  logic                start_ok;
  logic                last_ctx;
  logic                last_pass;
  logic [CTX_AW-1:0]   idx_inc;
  logic [WORD_W-1:0]   first_word;
  logic [WORD_W-1:0]   next_word;

  assign mem_we    = bus.cfg_we && (state_q == S_IDLE);
  assign start_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= DEPTH_L) && (bus.cfg_iter != '0);
  assign idx_inc   = idx_q + CTX_AW'(1);
  assign last_ctx  = ({1'b0, idx_q} == (len_q - (CTX_AW+1)'(1)));
  assign last_pass = (pass_q == (iter_q - ITER_W'(1)));
  assign next_word = mem_q[idx_inc];

  // A write to entry 0 in the same cycle as start must be seen by the first context.
  assign first_word = (mem_we && (bus.cfg_addr == '0)) ? bus.cfg_data : mem_q[0];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      switch_q <= IDLE_SWITCH;
      idx_q    <= '0;
      hold_q   <= '0;
      pass_q   <= '0;
      iter_q   <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      switch_q <= switch_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      pass_q   <= pass_d;
      iter_q   <= iter_d;
      len_q    <= len_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    switch_d = switch_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    pass_d   = pass_q;
    iter_d   = iter_q;
    len_d    = len_q;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            state_d  = S_RUN;
            len_d    = bus.cfg_len;
            iter_d   = bus.cfg_iter;
            switch_d = first_word[23:0];
            hold_d   = first_word[WORD_W-1:24];
            idx_d    = '0;
            pass_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        err_d = bus.cfg_we;
        // Abort outranks both stall and a completion landing in the same cycle.
        if (bus.abort) begin
          state_d  = S_IDLE;
          switch_d = IDLE_SWITCH;
          idx_d    = '0;
          hold_d   = '0;
          pass_d   = '0;
        end else if (!bus.stall) begin
          if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
          end else if (last_ctx) begin
            if (last_pass) begin
              state_d  = S_DONE;
              switch_d = IDLE_SWITCH;
              idx_d    = '0;
              pass_d   = '0;
            end else begin
              pass_d   = pass_q + ITER_W'(1);
              idx_d    = '0;
              switch_d = mem_q[0][23:0];
              hold_d   = mem_q[0][WORD_W-1:24];
            end
          end else begin
            idx_d    = idx_inc;
            switch_d = next_word[23:0];
            hold_d   = next_word[WORD_W-1:24];
          end
        end
      end

      S_DONE: begin
        err_d   = bus.cfg_we;
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        switch_d = IDLE_SWITCH;
        idx_d    = '0;
        hold_d   = '0;
        pass_d   = '0;
      end
    endcase
  end

  assign bus.switch  = switch_q;
  assign bus.ctx_idx = idx_q;
  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.cfg_err = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pe_switch_sequencer.sv
// Directed bench for pe_switch_sequencer: a table of per-cycle {inputs, expected outputs}
// followed by hand-written sequences for asynchronous reset and cycle-count checks.
module tb_pe_switch_sequencer;

  localparam logic [23:0] A = 24'h028888;
  localparam logic [23:0] B = 24'h830123;
  localparam logic [23:0] F = 24'hFFFFFF;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [27:0] data;
    logic [4:0]  len;
    logic [7:0]  iter;
    logic        start;
    logic        stall;
    logic        abort;
    logic [23:0] e_sw;
    logic [3:0]  e_idx;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dut_state;
  vec_t       vecs[$];
  int         n_vec = 0;
  int         n_err = 0;

  pe_switch_sequencer_if bus_if ();

  pe_switch_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .state_o (dut_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic we, input logic [3:0] addr, input logic [27:0] data,
                       input logic [4:0] len, input logic [7:0] iter,
                       input logic start, input logic stall, input logic abort);
    bus_if.cfg_we   = we;
    bus_if.cfg_addr = addr;
    bus_if.cfg_data = data;
    bus_if.cfg_len  = len;
    bus_if.cfg_iter = iter;
    bus_if.start    = start;
    bus_if.stall    = stall;
    bus_if.abort    = abort;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] sw, input logic [3:0] idx,
                       input logic busy, input logic done, input logic err);
    logic [1:0] exp_st;
    exp_st = busy ? 2'd1 : (done ? 2'd2 : 2'd0);
    n_vec++;
    if ({bus_if.switch, bus_if.ctx_idx, bus_if.busy, bus_if.done, bus_if.cfg_err, dut_state} !==
        {sw, idx, busy, done, err, exp_st}) begin
      n_err++;
      $display("FAIL %s: got sw=%h idx=%0d busy=%b done=%b err=%b st=%0d, want sw=%h idx=%0d busy=%b done=%b err=%b st=%0d",
               name, bus_if.switch, bus_if.ctx_idx, bus_if.busy, bus_if.done, bus_if.cfg_err,
               dut_state, sw, idx, busy, done, err, exp_st);
    end
  endtask

  // table builders
  task automatic add(input logic we, input logic [3:0] addr, input logic [27:0] data,
                     input logic [4:0] len, input logic [7:0] iter,
                     input logic start, input logic stall, input logic abort,
                     input logic [23:0] e_sw, input logic [3:0] e_idx,
                     input logic e_busy, input logic e_done, input logic e_err);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.len = len; v.iter = iter;
    v.start = start; v.stall = stall; v.abort = abort;
    v.e_sw = e_sw; v.e_idx = e_idx; v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic nop(input logic [23:0] sw, input logic [3:0] idx,
                     input logic busy, input logic done, input logic err);
    add(1'b0, 4'd0, 28'd0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, sw, idx, busy, done, err);
  endtask

  task automatic go(input logic [4:0] len, input logic [7:0] iter, input logic stall,
                    input logic [23:0] sw, input logic [3:0] idx,
                    input logic busy, input logic err);
    add(1'b0, 4'd0, 28'd0, len, iter, 1'b1, stall, 1'b0, sw, idx, busy, 1'b0, err);
  endtask

  initial begin
    int cyc;
    drive(1'b0, 4'd0, 28'd0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    check("reset", F, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // load ctx0 = {0, A}, ctx1 = {2, B}
    add(1'b1, 4'd0, {4'h0, A}, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, F, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'd1, {4'h2, B}, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, F, 4'd0, 1'b0, 1'b0, 1'b0);
    // basic run: len=2 iter=2
    go(5'd2, 8'd2, 1'b0, A, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) nop(B, 4'd1, 1'b1, 1'b0, 1'b0);
    nop(A, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) nop(B, 4'd1, 1'b1, 1'b0, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b1, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b0, 1'b0);
    // stall for 3 cycles during the second cycle of ctx1
    go(5'd2, 8'd2, 1'b0, A, 4'd0, 1'b1, 1'b0);
    nop(B, 4'd1, 1'b1, 1'b0, 1'b0);
    nop(B, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      add(1'b0, 4'd0, 28'd0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b0, B, 4'd1, 1'b1, 1'b0, 1'b0);
    nop(B, 4'd1, 1'b1, 1'b0, 1'b0);
    nop(A, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) nop(B, 4'd1, 1'b1, 1'b0, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b1, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b0, 1'b0);
    // stall ignored in IDLE; abort with stall in RUN cycle 2
    go(5'd2, 8'd2, 1'b1, A, 4'd0, 1'b1, 1'b0);
    nop(B, 4'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 28'd0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b1, F, 4'd0, 1'b0, 1'b0, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b0, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b0, 1'b0);
    // restart accepted after abort
    go(5'd1, 8'd1, 1'b0, A, 4'd0, 1'b1, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b1, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b0, 1'b0);
    // abort on the final RUN cycle beats completion
    go(5'd1, 8'd1, 1'b0, A, 4'd0, 1'b1, 1'b0);
    add(1'b0, 4'd0, 28'd0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b1, F, 4'd0, 1'b0, 1'b0, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b0, 1'b0);
    // illegal starts
    go(5'd0, 8'd2, 1'b0, F, 4'd0, 1'b0, 1'b1);
    nop(F, 4'd0, 1'b0, 1'b0, 1'b0);
    go(5'd2, 8'd0, 1'b0, F, 4'd0, 1'b0, 1'b1);
    go(5'd17, 8'd1, 1'b0, F, 4'd0, 1'b0, 1'b1);
    nop(F, 4'd0, 1'b0, 1'b0, 1'b0);
    // cfg_we while busy and while in DONE; start in DONE ignored
    go(5'd2, 8'd1, 1'b0, A, 4'd0, 1'b1, 1'b0);
    add(1'b1, 4'd0, {4'h0, 24'hABCDEF}, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, B, 4'd1, 1'b1, 1'b0, 1'b1);
    nop(B, 4'd1, 1'b1, 1'b0, 1'b0);
    nop(B, 4'd1, 1'b1, 1'b0, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 4'd1, {4'hF, 24'h000000}, 5'd1, 8'd1, 1'b1, 1'b0, 1'b0, F, 4'd0, 1'b0, 1'b0, 1'b1);
    nop(F, 4'd0, 1'b0, 1'b0, 1'b0);
    // memory unchanged by the rejected writes
    go(5'd2, 8'd1, 1'b0, A, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) nop(B, 4'd1, 1'b1, 1'b0, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b1, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b0, 1'b0);
    // same-cycle write to entry 0 and start: bypass
    add(1'b1, 4'd0, {4'h0, 24'h111111}, 5'd1, 8'd1, 1'b1, 1'b0, 1'b0, 24'h111111, 4'd0, 1'b1, 1'b0, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b1, 1'b0);
    nop(F, 4'd0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].len, vecs[i].iter,
            vecs[i].start, vecs[i].stall, vecs[i].abort);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_sw, vecs[i].e_idx, vecs[i].e_busy,
            vecs[i].e_done, vecs[i].e_err);
    end

    // asynchronous reset mid-run, then replay from ctx0
    drive(1'b1, 4'd0, {4'h0, A}, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("restore_ctx0", F, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 28'd0, 5'd2, 8'd2, 1'b1, 1'b0, 1'b0);
    step();
    check("pre_rst_a", A, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 28'd0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("pre_rst_b", B, 4'd1, 1'b1, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1 check("rst_async", F, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("rst_held", F, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 4'd0, 28'd0, 5'd2, 8'd2, 1'b1, 1'b0, 1'b0);
    step();
    check("replay_a", A, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 28'd0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("replay_b", B, 4'd1, 1'b1, 1'b0, 1'b0);

    // remaining run length to done, bounded
    cyc = 0;
    while (!bus_if.done && cyc < 20) begin
      step();
      cyc++;
    end
    n_vec++;
    if (cyc != 7) begin
      n_err++;
      $display("FAIL replay_len: got %0d cycles to done, want 7", cyc);
    end
    step();
    check("final_idle", F, 4'd0, 1'b0, 1'b0, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
